// File: rtl/mem_access.sv
// Memory-access pipeline stage: decodes load/store ops, runs a req/ack data-bus
// transaction with timeout, and formats load data for writeback.
module mem_access #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        addr_err,
  output logic        bus_err
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [7:0] CNT_MAX = 8'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;

  logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
  logic        is_mem, misalign, start;
  logic [1:0]  a;
  logic [3:0]  sel;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign a = mem_addr_i[1:0];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (aluop_i)
      EXE_LB_OP:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
      EXE_LH_OP:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
      EXE_LW_OP:  begin is_load  = 1'b1; is_word = 1'b1; end
      EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
      EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
      EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem   = is_load | is_store;
  assign misalign = (is_half & a[0]) | (is_word & (a != 2'b00));
  assign start    = (state == IDLE) & is_mem & ~misalign;
  assign addr_err = (state == IDLE) & is_mem & misalign;

  // Big-endian lanes: byte address 0 lives in bits 31:24.
  always_comb begin
    sel     = 4'b1111;
    st_data = reg2_i;
    if (is_byte) begin
      sel     = 4'b1000 >> a;
      st_data = {4{reg2_i[7:0]}};
    end else if (is_half) begin
      sel     = a[1] ? 4'b0011 : 4'b1100;
      st_data = {2{reg2_i[15:0]}};
    end
  end

  always_comb begin
    case (a)
      2'b00:   ld_byte = rdata_q[31:24];
      2'b01:   ld_byte = rdata_q[23:16];
      2'b10:   ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = a[1] ? rdata_q[15:0] : rdata_q[31:16];
    if (is_byte)
      ld_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
    else if (is_half)
      ld_data = {{16{is_signed & ld_half[15]}}, ld_half};
    else
      ld_data = rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= BUS;
          bus_req   <= 1'b1;
          bus_we    <= is_store;
          bus_addr  <= {mem_addr_i[31:2], 2'b00};
          bus_sel   <= sel;
          bus_wdata <= st_data;
          cnt       <= '0;
        end
        BUS: begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            bus_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == CNT_MAX) begin
            rdata_q <= '0;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // Unconditional return so a held instruction is never reissued.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o     = wd_i;
    wreg_o   = wreg_i;
    wdata_o  = wdata_i;
    stallreq = 1'b0;
    case (state)
      IDLE: if (is_mem) begin
        wreg_o   = 1'b0;
        stallreq = ~misalign;
      end
      BUS: begin
        wreg_o   = 1'b0;
        stallreq = 1'b1;
      end
      DONE: if (is_load) begin
        wreg_o  = wreg_i & ~bus_err;
        wdata_o = ld_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: load/store formatting, lanes, misalignment,
// timeout and mid-transaction reset.
module tb_mem_access;

  localparam logic [7:0] NOP = 8'h00;
  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;

  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  wd_i = '0, wd_o;
  logic        wreg_i = 1'b0, wreg_o;
  logic [31:0] wdata_i = '0, wdata_o;
  logic [7:0]  aluop_i = NOP;
  logic [31:0] mem_addr_i = '0, reg2_i = '0;
  logic        stallreq, bus_req, bus_we, addr_err, bus_err;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int tests = 0, fails = 0;

  mem_access #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access with same-cycle ack: IDLE-detect, one BUS cycle, DONE.
  task automatic mem_imm(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] reg2, input logic [31:0] rdata,
                         input logic [3:0] esel, input logic ewe, input logic [31:0] ebw,
                         input logic [31:0] eout);
    tick();
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wreg_i = 1'b1; wd_i = 5'd9; wdata_i = 32'h5A5A0000;
    @(negedge clk);
    chk({tag, " idle stall"}, stallreq, 1);
    chk({tag, " idle req"}, bus_req, 0);
    tick();
    bus_ack = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    chk({tag, " req"}, bus_req, 1);
    chk({tag, " sel"}, bus_sel, esel);
    chk({tag, " we"}, bus_we, ewe);
    chk({tag, " addr"}, bus_addr, {addr[31:2], 2'b00});
    if (ewe) chk({tag, " bwdata"}, bus_wdata, ebw);
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk({tag, " done stall"}, stallreq, 0);
    chk({tag, " done req"}, bus_req, 0);
    chk({tag, " wdata_o"}, wdata_o, eout);
    chk({tag, " wreg_o"}, wreg_o, 1);
    chk({tag, " wd_o"}, wd_o, 9);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst req", bus_req, 0);
    chk("rst addr", bus_addr, 0);
    chk("rst sel", bus_sel, 0);
    chk("rst wdata", bus_wdata, 0);
    chk("rst err", bus_err, 0);
    chk("rst stall", stallreq, 0);
    tick();
    rst = 1'b0;

    // Non-memory pass-through
    tick();
    aluop_i = 8'h21; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hCAFE0001;
    @(negedge clk);
    chk("nop wdata", wdata_o, 32'hCAFE0001);
    chk("nop wreg", wreg_o, 1);
    chk("nop wd", wd_o, 3);
    chk("nop stall", stallreq, 0);

    // LW 0x100, ack on 3rd BUS cycle: stallreq high 4 cycles
    tick();
    aluop_i = LW; mem_addr_i = 32'h100; wreg_i = 1'b1; wdata_i = 32'h100; wd_i = 5'd7;
    @(negedge clk);
    chk("lw c0 stall", stallreq, 1);
    chk("lw c0 wreg", wreg_o, 0);
    chk("lw c0 req", bus_req, 0);
    tick();
    @(negedge clk);
    chk("lw b1 req", bus_req, 1);
    chk("lw b1 sel", bus_sel, 4'b1111);
    chk("lw b1 addr", bus_addr, 32'h100);
    chk("lw b1 we", bus_we, 0);
    chk("lw b1 stall", stallreq, 1);
    tick();
    @(negedge clk);
    chk("lw b2 stall", stallreq, 1);
    chk("lw b2 wreg", wreg_o, 0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h89ABCDEF;
    @(negedge clk);
    chk("lw b3 stall", stallreq, 1);
    chk("lw b3 req", bus_req, 1);
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("lw done stall", stallreq, 0);
    chk("lw done wdata", wdata_o, 32'h89ABCDEF);
    chk("lw done wreg", wreg_o, 1);
    chk("lw done err", bus_err, 0);

    // Back-to-back: LB straight after DONE, then LBU, LH, LHU, stores
    mem_imm("lb", LB, 32'h103, 32'h0, 32'h00000080, 4'b0001, 1'b0, 32'h0, 32'hFFFFFF80);
    mem_imm("lbu", LBU, 32'h103, 32'h0, 32'h00000080, 4'b0001, 1'b0, 32'h0, 32'h00000080);
    mem_imm("lb0", LB, 32'h100, 32'h0, 32'h7F123456, 4'b1000, 1'b0, 32'h0, 32'h0000007F);
    mem_imm("lh", LH, 32'h102, 32'h0, 32'h12348001, 4'b0011, 1'b0, 32'h0, 32'hFFFF8001);
    mem_imm("lhu", LHU, 32'h100, 32'h0, 32'h80011234, 4'b1100, 1'b0, 32'h0, 32'h00008001);
    mem_imm("sh", SH, 32'h202, 32'h1234ABCD, 32'h0, 4'b0011, 1'b1, 32'hABCDABCD, 32'h5A5A0000);
    mem_imm("sb", SB, 32'h201, 32'h000000CD, 32'h0, 4'b0100, 1'b1, 32'hCDCDCDCD, 32'h5A5A0000);
    tick();
    aluop_i = NOP;
    @(negedge clk);
    chk("gap req", bus_req, 0);

    // Misaligned LW / LH
    tick();
    aluop_i = LW; mem_addr_i = 32'h101; wreg_i = 1'b1;
    @(negedge clk);
    chk("mis lw aerr", addr_err, 1);
    chk("mis lw stall", stallreq, 0);
    chk("mis lw wreg", wreg_o, 0);
    tick();
    aluop_i = LH; mem_addr_i = 32'h103;
    @(negedge clk);
    chk("mis lh aerr", addr_err, 1);
    chk("mis req", bus_req, 0);
    tick();
    aluop_i = NOP;
    @(negedge clk);
    chk("mis clr aerr", addr_err, 0);
    chk("mis after req", bus_req, 0);

    // Timeout with BUS_TIMEOUT=4
    tick();
    aluop_i = LW; mem_addr_i = 32'h300; wreg_i = 1'b1; wdata_i = 32'h300;
    @(negedge clk);
    chk("to c0 stall", stallreq, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("to bus%0d req", i), bus_req, 1);
      chk($sformatf("to bus%0d err", i), bus_err, 0);
    end
    tick();
    @(negedge clk);
    chk("to done req", bus_req, 0);
    chk("to done err", bus_err, 1);
    chk("to done wreg", wreg_o, 0);
    chk("to done stall", stallreq, 0);
    chk("to done wdata", wdata_o, 0);
    tick();
    aluop_i = NOP;
    @(negedge clk);
    chk("to idle err", bus_err, 0);
    chk("to idle req", bus_req, 0);

    // Reset during the 2nd BUS cycle, then a late ack
    tick();
    aluop_i = LW; mem_addr_i = 32'h400;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rr b1 req", bus_req, 1);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("rr req", bus_req, 0);
    chk("rr addr", bus_addr, 0);
    chk("rr sel", bus_sel, 0);
    tick();
    rst = 1'b0; aluop_i = NOP; wdata_i = 32'h0BAD0000;
    @(negedge clk);
    chk("rr post stall", stallreq, 0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("late ack req", bus_req, 0);
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("late ack req2", bus_req, 0);
    chk("late ack stall", stallreq, 0);
    chk("late ack wdata", wdata_o, 32'h0BAD0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
